modbus_bus_arbiter: RTL and testbench
=====================================

MODBUS_BUS_ARBITER -- requirements
Module: modbus_bus_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 255: downstream ack timeout in clk cycles; only used when ARB_TIMEOUT_EN is defined.
REQ-002 Parameter TMO_RDATA, default 16'hDEAD: rdata returned on a timed-out access.
REQ-003 Port clk  input  1  clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports s0_valid, s0_iswrite  input  1  requester 0 request and direction; request held until s0_ack.
REQ-006 Ports s0_addr, s0_wdata  input  16  requester 0 address and write data; stable while s0_valid.
REQ-007 Port s0_rdata  output  16  requester 0 read data; valid when s0_ack.
REQ-008 Port s0_ack  output  1  requester 0 completion, single-cycle pulse.
REQ-009 Ports s1_valid, s1_iswrite, s1_addr, s1_wdata, s1_rdata, s1_ack: requester 1, same widths and meanings as REQ-005..REQ-008.
REQ-010 Ports m_valid, m_iswrite  output  1  downstream request and direction.
REQ-011 Ports m_addr, m_wdata  output  16  downstream address and write data.
REQ-012 Port m_rdata  input  16  downstream read data, valid with m_ack.
REQ-013 Port m_ack  input  1  downstream completion pulse.
REQ-014 Port grant  output  2  one-hot current owner (bit0 = s0, bit1 = s1); 2'b00 when idle.
REQ-015 Port tmo_err  output  1  single-cycle pulse on a timed-out access.

Function
REQ-016 FSM states: IDLE, BUSY0, BUSY1, RELEASE.
REQ-017 IDLE: when only sN_valid is high, latch sN_iswrite/addr/wdata into m_* and go to BUSYN; m_valid rises the next cycle.
REQ-018 IDLE with s0_valid and s1_valid both high: grant the requester not granted last (round-robin); after reset, last = 1, so s0 wins first.
REQ-019 BUSYN: m_valid high, m_* held constant; the other requester is ignored, and it holds its request.
REQ-020 BUSYN with m_ack: next cycle sN_ack = 1 for exactly one cycle, sN_rdata = m_rdata latched at m_ack (writes too), m_valid = 0, state = RELEASE, last = N.
REQ-021 RELEASE lasts exactly one cycle, then IDLE; requesters are not sampled in RELEASE, so a valid dropping after ack is never re-granted.
REQ-022 Minimum latency: sN_valid rise at cycle T, m_ack at T+1 -> sN_ack at T+2; next grant at T+3 earliest.
REQ-023 m_ack while IDLE or RELEASE is ignored; no sN_ack is produced.
REQ-024 Requester dropping sN_valid before ack (protocol violation): the access completes downstream and sN_ack still pulses.
REQ-025 sN_rdata holds its last value between acks; sN_ack is never asserted for the non-owner.
REQ-026 grant equals {state==BUSY1, state==BUSY0}.

Reset
REQ-027 Reset forces state IDLE, last = 1, m_valid = 0, m_iswrite = 0, m_addr = 0, m_wdata = 0, s0_ack = s1_ack = 0, s0_rdata = s1_rdata = 0, grant = 0, tmo_err = 0, timeout counter = 0.
REQ-028 Reset mid-access abandons the access with no sN_ack; a later m_ack is ignored per REQ-023.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN: when defined, a counter clears on entry to BUSYN and increments each BUSYN cycle without m_ack.
REQ-030 Expiry at count == TMO_CYCLES without m_ack: next cycle sN_ack = 1, sN_rdata = TMO_RDATA, tmo_err = 1 (one cycle), m_valid = 0, state = RELEASE.
REQ-031 m_ack in the same cycle as expiry takes priority: normal completion, no tmo_err.
REQ-032 When ARB_TIMEOUT_EN is undefined: no counter; BUSYN waits indefinitely for m_ack; tmo_err is tied 0.

Verification
REQ-033 s0 read addr 0x0010, m_ack one cycle after m_valid with m_rdata 0x1234 -> s0_ack 2 cycles after s0_valid, s0_rdata 0x1234, grant 01 then 00.
REQ-034 s0 and s1 valid in the same cycle, 3 back-to-back rounds -> grants s0, s1, s0; each ack goes only to its owner.
REQ-035 s1 write addr 0x0100 data 0xBEEF while s0 requests mid-access -> m_addr/m_wdata stay 0x0100/0xBEEF until m_ack; s0 is served after RELEASE.
REQ-036 Stray m_ack while IDLE -> no s0_ack/s1_ack, state unchanged.
REQ-037 ARB_TIMEOUT_EN, TMO_CYCLES = 4, no m_ack -> s0_ack with s0_rdata 0xDEAD and one-cycle tmo_err; without the macro, stays BUSY0 after 1000 cycles.
REQ-038 Reset asserted during BUSY1 -> all outputs at reset values the next cycle; a following m_ack produces no ack.

Source files
------------

// File: rtl/modbus_bus_arbiter_if.sv
// Bus bundle for modbus_bus_arbiter: two requester ports, the downstream
// port and the grant/timeout status lines.
interface modbus_bus_arbiter_if;
    logic        s0_valid;
    logic        s0_iswrite;
    logic [15:0] s0_addr;
    logic [15:0] s0_wdata;
    logic [15:0] s0_rdata;
    logic        s0_ack;

    logic        s1_valid;
    logic        s1_iswrite;
    logic [15:0] s1_addr;
    logic [15:0] s1_wdata;
    logic [15:0] s1_rdata;
    logic        s1_ack;

    logic        m_valid;
    logic        m_iswrite;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ack;

    logic [1:0]  grant;
    logic        tmo_err;

    // arbiter side
    modport slave (
        input  s0_valid, s0_iswrite, s0_addr, s0_wdata,
        output s0_rdata, s0_ack,
        input  s1_valid, s1_iswrite, s1_addr, s1_wdata,
        output s1_rdata, s1_ack,
        output m_valid, m_iswrite, m_addr, m_wdata,
        input  m_rdata, m_ack,
        output grant, tmo_err
    );

    // requester/downstream environment side
    modport master (
        output s0_valid, s0_iswrite, s0_addr, s0_wdata,
        input  s0_rdata, s0_ack,
        output s1_valid, s1_iswrite, s1_addr, s1_wdata,
        input  s1_rdata, s1_ack,
        input  m_valid, m_iswrite, m_addr, m_wdata,
        output m_rdata, m_ack,
        input  grant, tmo_err
    );
endinterface

// File: rtl/modbus_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single downstream bus.
// Optional ack timeout enabled by defining ARB_TIMEOUT_EN.
module modbus_bus_arbiter #(
    parameter int          TMO_CYCLES = 255,
    parameter logic [15:0] TMO_RDATA  = 16'hDEAD
) (
    input logic           clk,
    input logic           reset,
    modbus_bus_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY0   = 2'd1;
    localparam logic [1:0] ST_BUSY1   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]  r_state;
    logic        r_last;
    logic        r_m_valid;
    logic        r_m_iswrite;
    logic [15:0] r_m_addr;
    logic [15:0] r_m_wdata;
    logic        r_s0_ack;
    logic        r_s1_ack;
    logic [15:0] r_s0_rdata;
    logic [15:0] r_s1_rdata;

    logic        w_pick0;
    logic        w_pick1;
    logic        w_busy;
    logic        w_own1;
    logic        w_expire;
    logic [15:0] w_rdata;

    // on a tie, r_last = 1 means s1 was served last so s0 goes next
    assign w_pick0 = bus.s0_valid & (~bus.s1_valid | r_last);
    assign w_pick1 = bus.s1_valid & ~w_pick0;
    assign w_busy  = (r_state == ST_BUSY0) | (r_state == ST_BUSY1);
    assign w_own1  = (r_state == ST_BUSY1);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TMO_CYCLES < 1) ? 1 : $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_tmo_err;

    assign w_expire = w_busy & ~bus.m_ack & (r_cnt == CW'(TMO_CYCLES));
    assign w_rdata  = bus.m_ack ? bus.m_rdata : TMO_RDATA;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_expire;
            if (!w_busy)
                r_cnt <= '0;
            else if (!bus.m_ack && !w_expire)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bus.tmo_err = r_tmo_err;
`else
    assign w_expire    = 1'b0;
    assign w_rdata     = bus.m_rdata;
    assign bus.tmo_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_iswrite <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_s0_ack    <= 1'b0;
            r_s1_ack    <= 1'b0;
            r_s0_rdata  <= '0;
            r_s1_rdata  <= '0;
        end else begin
            r_s0_ack <= 1'b0;
            r_s1_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick0 | w_pick1) begin
                        r_state     <= w_pick0 ? ST_BUSY0 : ST_BUSY1;
                        r_m_valid   <= 1'b1;
                        r_m_iswrite <= w_pick0 ? bus.s0_iswrite : bus.s1_iswrite;
                        r_m_addr    <= w_pick0 ? bus.s0_addr : bus.s1_addr;
                        r_m_wdata   <= w_pick0 ? bus.s0_wdata : bus.s1_wdata;
                    end
                end
                ST_BUSY0, ST_BUSY1: begin
                    if (bus.m_ack | w_expire) begin
                        r_state   <= ST_RELEASE;
                        r_m_valid <= 1'b0;
                        r_last    <= w_own1;
                        if (w_own1) begin
                            r_s1_ack   <= 1'b1;
                            r_s1_rdata <= w_rdata;
                        end else begin
                            r_s0_ack   <= 1'b1;
                            r_s0_rdata <= w_rdata;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_valid   = r_m_valid;
    assign bus.m_iswrite = r_m_iswrite;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_wdata   = r_m_wdata;
    assign bus.s0_ack    = r_s0_ack;
    assign bus.s1_ack    = r_s1_ack;
    assign bus.s0_rdata  = r_s0_rdata;
    assign bus.s1_rdata  = r_s1_rdata;
    assign bus.grant     = {r_state == ST_BUSY1, r_state == ST_BUSY0};
endmodule

// File: tb/tb_modbus_bus_arbiter.sv
// Self-checking bench for modbus_bus_arbiter: transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_modbus_bus_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int          TMO = 4;
    localparam logic [15:0] TRD = 16'hDEAD;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    modbus_bus_arbiter_if bus();

    modbus_bus_arbiter #(
        .TMO_CYCLES(TMO),
        .TMO_RDATA (TRD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit armed  = 1'b0;

    function automatic void chk(string nm, logic [79:0] act, logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    int          own  = -1;
    int          last = 1;
    int          wait_cyc = 0;
    bit          cooling  = 1'b0;
    logic        e_mv, e_mw, e_tmo;
    logic [15:0] e_ma, e_md;
    logic [1:0]  e_ack;
    logic [15:0] e_rd [2];

    function automatic logic [1:0] own_bits(int o);
        return (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic finish_access(logic [15:0] d, bit t);
        e_ack[own] = 1'b1;
        e_rd[own]  = d;
        e_tmo      = t;
        e_mv       = 1'b0;
        last       = own;
        own        = -1;
        cooling    = 1'b1;
    endtask

    always @(posedge clk) begin : model
        bit          v [2];
        bit          w [2];
        logic [15:0] a [2];
        logic [15:0] d [2];
        int          win;
        v[0] = bus.s0_valid;   v[1] = bus.s1_valid;
        w[0] = bus.s0_iswrite; w[1] = bus.s1_iswrite;
        a[0] = bus.s0_addr;    a[1] = bus.s1_addr;
        d[0] = bus.s0_wdata;   d[1] = bus.s1_wdata;
        if (reset) begin
            own = -1; last = 1; wait_cyc = 0; cooling = 1'b0;
            e_mv = 0; e_mw = 0; e_ma = 0; e_md = 0;
            e_ack = 0; e_tmo = 0; e_rd[0] = 0; e_rd[1] = 0;
        end else begin
            e_ack = 0;
            e_tmo = 0;
            if (cooling) begin
                cooling = 1'b0;
            end else if (own < 0) begin
                win = -1;
                if (v[0] && v[1]) win = 1 - last;
                else if (v[0])    win = 0;
                else if (v[1])    win = 1;
                if (win >= 0) begin
                    own = win; wait_cyc = 0;
                    e_mv = 1'b1; e_mw = w[win]; e_ma = a[win]; e_md = d[win];
                end
            end else if (bus.m_ack) begin
                finish_access(bus.m_rdata, 1'b0);
            end else if (TMO_ON && wait_cyc == TMO) begin
                finish_access(TRD, 1'b1);
            end else begin
                wait_cyc++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed)
            chk("cycle",
                {9'b0, bus.m_valid, bus.m_iswrite, bus.m_addr, bus.m_wdata,
                 bus.s0_ack, bus.s1_ack, bus.s0_rdata, bus.s1_rdata,
                 bus.grant, bus.tmo_err},
                {9'b0, e_mv, e_mw, e_ma, e_md, e_ack[0], e_ack[1],
                 e_rd[0], e_rd[1], own_bits(own), e_tmo});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(int s, bit v, bit w, logic [15:0] a, logic [15:0] d);
        if (s == 0) begin
            bus.s0_valid = v; bus.s0_iswrite = w; bus.s0_addr = a; bus.s0_wdata = d;
        end else begin
            bus.s1_valid = v; bus.s1_iswrite = w; bus.s1_addr = a; bus.s1_wdata = d;
        end
    endtask

    function automatic logic sig(int which);
        return (which == 0) ? bus.s0_ack : (which == 1) ? bus.s1_ack : bus.m_valid;
    endfunction

    task automatic wait_sig(string nm, int which, int budget);
        int k = 0;
        while (!sig(which) && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, {79'b0, sig(which)}, 80'd1);
    endtask

    logic [1:0] rr_exp [3];

    initial begin
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
        req(0, 0, 0, 0, 0);
        req(1, 0, 0, 0, 0);
        bus.m_ack = 1'b0;
        bus.m_rdata = '0;
        cyc(1);
        armed = 1'b1;
        cyc(1);
        chk("reset_state",
            {9'b0, bus.m_valid, bus.m_iswrite, bus.m_addr, bus.m_wdata,
             bus.s0_ack, bus.s1_ack, bus.s0_rdata, bus.s1_rdata,
             bus.grant, bus.tmo_err}, 80'h0);
        reset = 1'b0;
        cyc(1);

        // single read by s0
        req(0, 1, 0, 16'h0010, 16'h0);
        cyc(1);
        chk("rd_grant", {62'b0, bus.grant, bus.m_valid, bus.m_addr}, {62'b0, 2'b01, 1'b1, 16'h0010});
        bus.m_ack = 1'b1; bus.m_rdata = 16'h1234;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("rd_ack", {61'b0, bus.s0_ack, bus.grant, bus.s0_rdata}, {61'b0, 1'b1, 2'b00, 16'h1234});
        req(0, 0, 0, 16'h0010, 16'h0);
        cyc(1);

        // stray downstream ack while idle
        bus.m_ack = 1'b1; bus.m_rdata = 16'h5555;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("stray_ack", {60'b0, bus.s0_ack, bus.s1_ack, bus.grant, bus.s0_rdata},
            {60'b0, 2'b00, 2'b00, 16'h1234});

        // round-robin from reset
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        for (int r = 0; r < 3; r++) begin
            req(0, 1, 0, 16'h0A00 + 16'(r), 16'h0);
            req(1, 1, 1, 16'h0B00 + 16'(r), 16'hC000 + 16'(r));
            cyc(1);
            chk("rr_grant", {78'b0, bus.grant}, {78'b0, rr_exp[r]});
            bus.m_ack = 1'b1; bus.m_rdata = 16'h7000 + 16'(r);
            cyc(1);
            bus.m_ack = 1'b0;
            chk("rr_ack", {78'b0, bus.s0_ack, bus.s1_ack}, {78'b0, rr_exp[r][0], rr_exp[r][1]});
            req(0, 0, 0, 16'h0, 16'h0);
            req(1, 0, 0, 16'h0, 16'h0);
            cyc(1);
        end

        // s1 write held while s0 requests mid-access
        req(1, 1, 1, 16'h0100, 16'hBEEF);
        cyc(1);
        chk("wr_grant", {78'b0, bus.grant}, {78'b0, 2'b10});
        req(0, 1, 0, 16'h0200, 16'h0);
        for (int k = 0; k < 3; k++) begin
            chk("wr_hold", {45'b0, bus.grant, bus.m_iswrite, bus.m_addr, bus.m_wdata},
                {45'b0, 2'b10, 1'b1, 16'h0100, 16'hBEEF});
            cyc(1);
        end
        bus.m_ack = 1'b1; bus.m_rdata = 16'h0;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("wr_ack", {78'b0, bus.s0_ack, bus.s1_ack}, {78'b0, 2'b01});
        req(1, 0, 0, 16'h0, 16'h0);
        wait_sig("s0_after_rel", 2, 6);
        chk("s0_after_rel_addr", {62'b0, bus.grant, bus.m_addr}, {62'b0, 2'b01, 16'h0200});
        bus.m_ack = 1'b1; bus.m_rdata = 16'h4242;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("s0_after_rel_ack", {63'b0, bus.s0_ack, bus.s0_rdata}, {63'b0, 1'b1, 16'h4242});
        req(0, 0, 0, 16'h0, 16'h0);
        cyc(1);

        // requester drops valid before ack
        req(0, 1, 0, 16'h0300, 16'h0);
        cyc(1);
        req(0, 0, 0, 16'h0300, 16'h0);
        cyc(2);
        bus.m_ack = 1'b1; bus.m_rdata = 16'h0BAD;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("drop_ack", {63'b0, bus.s0_ack, bus.s0_rdata}, {63'b0, 1'b1, 16'h0BAD});
        cyc(1);

        // no downstream ack
        req(0, 1, 0, 16'h0400, 16'h0);
        cyc(1);
        chk("tmo_grant", {78'b0, bus.grant}, {78'b0, 2'b01});
`ifdef ARB_TIMEOUT_EN
        wait_sig("tmo_ack", 0, 20);
        chk("tmo_data", {62'b0, bus.s0_ack, bus.tmo_err, bus.s0_rdata}, {62'b0, 2'b11, 16'hDEAD});
        req(0, 0, 0, 16'h0, 16'h0);
        cyc(1);
        chk("tmo_pulse", {79'b0, bus.tmo_err}, 80'h0);
`else
        cyc(1000);
        chk("no_tmo", {61'b0, bus.grant, bus.m_valid, bus.m_addr}, {61'b0, 2'b01, 1'b1, 16'h0400});
        bus.m_ack = 1'b1; bus.m_rdata = 16'h1111;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("no_tmo_ack", {62'b0, bus.s0_ack, bus.tmo_err, bus.s0_rdata}, {62'b0, 2'b10, 16'h1111});
        req(0, 0, 0, 16'h0, 16'h0);
        cyc(1);
`endif
        cyc(1);

        // reset in the middle of an s1 access
        req(1, 1, 1, 16'h0500, 16'h0600);
        cyc(1);
        chk("mid_grant", {78'b0, bus.grant}, {78'b0, 2'b10});
        reset = 1'b1;
        cyc(1);
        chk("mid_reset",
            {9'b0, bus.m_valid, bus.m_iswrite, bus.m_addr, bus.m_wdata,
             bus.s0_ack, bus.s1_ack, bus.s0_rdata, bus.s1_rdata,
             bus.grant, bus.tmo_err}, 80'h0);
        reset = 1'b0;
        req(1, 0, 0, 16'h0, 16'h0);
        cyc(1);
        bus.m_ack = 1'b1; bus.m_rdata = 16'h2222;
        cyc(1);
        bus.m_ack = 1'b0;
        chk("post_reset_ack", {75'b0, bus.s0_ack, bus.s1_ack, bus.grant, bus.m_valid}, 80'h0);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
